// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared types and constants for the carry-save accumulator
//
// Purpose: FSM state enumeration and the resolve slice width used by
//          csa_accumulator and csa_ripple4.
// Ports:   none (package)

package csa_pkg;

  // Width of one resolve step; the accumulator is resolved this many bits per cycle.
  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ACC     = 2'd0,
    RESOLVE = 2'd1,
    OUT     = 2'd2
  } csa_state_t;

endpackage

// File: rtl/csa_ripple4.sv
// rtl/csa_ripple4.sv - 4-bit ripple-carry adder slice used to resolve S+C
//
// Purpose: adds one SLICE_W-bit slice of the sum and carry vectors plus a
//          carry-in from the previous (less significant) slice.
// Ports:   a, b  - slice operands
//          cin   - carry from the previous slice
//          sum   - slice result
//          cout  - carry into the next slice

module csa_ripple4
  import csa_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W:0] c;

  always_comb begin
    sum  = '0;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
    end
    cout = c[SLICE_W];
  end

endmodule

// File: rtl/csa_accumulator.sv
// rtl/csa_accumulator.sv - carry-save group accumulator with sliced final resolve
//
// Purpose: accumulates groups of unsigned operands in redundant (sum/carry)
//          form, one operand per cycle, then resolves S+C SLICE_W bits per
//          cycle through a single time-multiplexed csa_ripple4 and presents
//          the group sum with a valid/ready handshake.
// Ports:   clk, rst                       - clock, synchronous active-high reset
//          in_valid/in_ready/in_data/in_last - operand stream, in_last ends a group
//          out_valid/out_ready            - result handshake
//          out_sum                        - group sum modulo 2^ACC_W
//          out_ovf                        - group sum did not fit in ACC_W bits
// Config:  CSA_ACC_OVF_EN - when defined, a sticky overflow flag drives
//          out_ovf; otherwise out_ovf is tied to 0.

module csa_accumulator
  import csa_pkg::*;
#(
  parameter int W     = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int NSL   = ACC_W / SLICE_W;
  localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);

  csa_state_t state_q, state_d;

  logic [ACC_W-1:0]   s_q, c_q, sum_q;
  logic [ACC_W-1:0]   x, maj;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic               xfer, last_slice;
  logic [SLICE_W-1:0] sl_a, sl_b, sl_sum;
  logic               sl_cout;

  assign in_ready   = (state_q == ACC);
  assign out_valid  = (state_q == OUT);
  assign xfer       = in_valid & in_ready;
  assign x          = ACC_W'(in_data);
  assign maj        = (s_q & c_q) | (s_q & x) | (c_q & x);
  assign last_slice = (idx_q == LAST_IDX);
  assign out_sum    = sum_q;

  // Select the current slice of S and C for the shared adder.
  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int i = 0; i < NSL; i++) begin
      if (idx_q == i[IDX_W-1:0]) begin
        sl_a = s_q[i*SLICE_W +: SLICE_W];
        sl_b = c_q[i*SLICE_W +: SLICE_W];
      end
    end
  end

  csa_ripple4 u_ripple4 (
    .a    (sl_a),
    .b    (sl_b),
    .cin  (carry_q),
    .sum  (sl_sum),
    .cout (sl_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ACC;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ACC:     if (xfer && in_last) state_d = RESOLVE;
      RESOLVE: if (last_slice)      state_d = OUT;
      OUT:     if (out_ready)       state_d = ACC;
      default:                      state_d = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q     <= '0;
      c_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      case (state_q)
        ACC: begin
          if (xfer) begin
            s_q     <= s_q ^ c_q ^ x;
            c_q     <= maj << 1;
            idx_q   <= '0;
            carry_q <= 1'b0;
          end
        end
        RESOLVE: begin
          for (int i = 0; i < NSL; i++) begin
            if (idx_q == i[IDX_W-1:0]) sum_q[i*SLICE_W +: SLICE_W] <= sl_sum;
          end
          carry_q <= sl_cout;
          idx_q   <= last_slice ? '0 : idx_q + 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            s_q <= '0;
            c_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CSA_ACC_OVF_EN
  logic ovf_q;

  // Sticky: a carry dropped off the top of C, or a carry out of the top
  // resolve slice, means the true group sum needs more than ACC_W bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      case (state_q)
        ACC:     if (xfer && maj[ACC_W-1])    ovf_q <= 1'b1;
        RESOLVE: if (last_slice && sl_cout)   ovf_q <= 1'b1;
        OUT:     if (out_ready)               ovf_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign out_ovf = ovf_q;
`else
  assign out_ovf = 1'b0;
`endif

endmodule

// File: tb/tb_csa_accumulator.sv
// tb/tb_csa_accumulator.sv - scoreboard testbench for csa_accumulator

module tb_csa_accumulator;

  localparam int W     = 4;
  localparam int ACC_W = 8;
  localparam int LAT   = ACC_W / 4 + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  always #5 clk = ~clk;

  csa_accumulator #(.W(W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  typedef struct {
    logic [ACC_W-1:0] sum;
    logic             ovf;
    int               xfer_cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   bp_mode = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0
  int   model_sum = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic model_ovf(input int s);
`ifdef CSA_ACC_OVF_EN
    return (s > (1 << ACC_W) - 1);
`else
    return 1'b0;
`endif
  endfunction

  // Consumer backpressure
  initial forever begin
    @(posedge clk);
    #1;
    case (bp_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  // Monitor: compares each presented result against the scoreboard head
  logic             prev_valid = 1'b0;
  logic [ACC_W-1:0] held_sum;
  logic             held_ovf;
  exp_t             mon_e;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (!prev_valid) begin
          if (sb.size() == 0) check("unexpected_result", 1, 0);
          else                check("latency", cyc - sb[0].xfer_cyc, LAT);
          held_sum = out_sum;
          held_ovf = out_ovf;
        end else begin
          check("hold_sum", out_sum, held_sum);
          check("hold_ovf", out_ovf, held_ovf);
        end
        check("in_ready_during_out", in_ready, 0);
        if (out_ready && sb.size() > 0) begin
          mon_e = sb.pop_front();
          check("out_sum", out_sum, mon_e.sum);
          check("out_ovf", out_ovf, mon_e.ovf);
        end
      end
      prev_valid = out_valid && !out_ready;
    end
  end

  // Present one operand after `gap` idle cycles; returns at posedge+1 after the transfer.
  task automatic send(input logic [W-1:0] d, input logic last, input int gap, input bit record);
    int   n;
    logic rdy;
    exp_t e;
    repeat (gap) begin
      in_valid = 1'b0;
      in_data  = W'($urandom);
      in_last  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    n   = 0;
    rdy = 1'b0;
    while (!rdy && n < 200) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!rdy) check("in_ready_timeout", 0, 1);
    in_valid = 1'b0;
    in_data  = W'($urandom);
    in_last  = 1'b0;
    model_sum += int'(d);
    if (last) begin
      if (record) begin
        e.sum      = ACC_W'(model_sum);
        e.ovf      = model_ovf(model_sum);
        e.xfer_cyc = cyc - 1;
        sb.push_back(e);
      end
      model_sum = 0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check("drain_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int len;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_sum", out_sum, 0);
    check("reset_out_ovf", out_ovf, 0);
    @(posedge clk);
    #1;

    send(4'd4, 1'b0, 0, 1'b1);
    send(4'd5, 1'b0, 0, 1'b1);
    send(4'd9, 1'b1, 0, 1'b1);
    drain();

    send(4'd7, 1'b1, 0, 1'b1);
    drain();

    repeat (17) send(4'd15, 1'b0, 0, 1'b1);
    send(4'd15, 1'b1, 0, 1'b1);
    drain();

    // Hold the result under backpressure, then check the next group starts clean
    bp_mode = 2;
    send(4'd10, 1'b0, 0, 1'b1);
    send(4'd11, 1'b1, 0, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("out_valid_timeout", 0, 1);
    repeat (5) @(negedge clk);
    check("bp_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    bp_mode = 0;
    send(4'd2, 1'b0, 0, 1'b1);
    send(4'd4, 1'b1, 0, 1'b1);
    drain();

    // Reset during the second resolve cycle discards the group
    send(4'd5, 1'b0, 0, 1'b0);
    send(4'd6, 1'b1, 0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    send(4'd3, 1'b0, 0, 1'b1);
    send(4'd3, 1'b1, 0, 1'b1);
    drain();

    // Idle gaps between operands
    send(4'd1, 1'b0, 3, 1'b1);
    send(4'd2, 1'b0, 2, 1'b1);
    send(4'd3, 1'b1, 4, 1'b1);
    drain();

    // Random groups with random consumer backpressure
    bp_mode = 1;
    for (int g = 0; g < 25; g++) begin
      len = $urandom_range(1, 30);
      for (int k = 0; k < len; k++)
        send(W'($urandom), (k == len - 1), $urandom_range(0, 2), 1'b1);
    end
    bp_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
